// File: rtl/count_pkg.sv
// Shared types and constants for the modulo count limiter.
// Limit-region FSM state encoding and range-end mode selectors.
package count_pkg;

    typedef enum logic {
        ST_BELOW = 1'b0,
        ST_ABOVE = 1'b1
    } state_t;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

endpackage

// File: rtl/modulo_count_limiter_if.sv
// Control/status bundle for modulo_count_limiter; master drives requests, slave is the counter.
// Purely wiring: no latency, no backpressure (requests are accepted every cycle).
interface modulo_count_limiter_if #(
    parameter int WIDTH = 7
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             inc;
    logic             dec;
    logic             alarm_ack;

    logic [WIDTH-1:0] count;
    logic             above_limit;
    logic             at_max;
    logic             at_min;
    logic             ovf_pulse;
    logic             unf_pulse;
    logic             alarm;

    modport master (
        output clear, load, load_data, inc, dec, alarm_ack,
        input  count, above_limit, at_max, at_min, ovf_pulse, unf_pulse, alarm
    );

    modport slave (
        input  clear, load, load_data, inc, dec, alarm_ack,
        output count, above_limit, at_max, at_min, ovf_pulse, unf_pulse, alarm
    );

endinterface

// File: rtl/limit_compare.sv
// Combinational limit comparator on the next count value.
// Zero latency; no backpressure.
module limit_compare #(
    parameter int WIDTH = 7,
    parameter int LIMIT = 99,
    parameter int HYST  = 0
) (
    input  logic [WIDTH-1:0] next_count,
    output logic             gt_limit,
    output logic             le_release
);

    localparam int               REL     = LIMIT - HYST;
    localparam logic [WIDTH-1:0] LIMIT_V = LIMIT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] REL_V   = REL[WIDTH-1:0];

    assign gt_limit   = (next_count > LIMIT_V);
    assign le_release = (next_count <= REL_V);

endmodule

// File: rtl/modulo_count_limiter.sv
// Up/down modulo counter with hysteretic limit flag, range-end pulses and alarm; count latency 1 cycle, no backpressure.
// Optional feature macro LIMIT_ALARM_LATCH_EN: makes alarm sticky until alarm_ack.
module modulo_count_limiter
    import count_pkg::*;
#(
    parameter int WIDTH    = 7,
    parameter int MAX_VAL  = 127,
    parameter int LIMIT    = 99,
    parameter int HYST     = 0,
    parameter int SAT_MODE = MODE_WRAP
) (
    input  logic                 clk,
    input  logic                 rst_n,
    modulo_count_limiter_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_V = MAX_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] next_count;
    logic             ovf_d, unf_d, ovf_q, unf_q;
    logic             gt_limit, le_release, entry;
    state_t           state_q, state_d;

    // Priority: clear, load, then inc/dec; opposing inc+dec cancel out.
    always_comb begin
        next_count = count_q;
        ovf_d      = 1'b0;
        unf_d      = 1'b0;
        if (bus.clear) begin
            next_count = '0;
        end else if (bus.load) begin
            next_count = (bus.load_data > MAX_V) ? MAX_V : bus.load_data;
        end else if (bus.inc && !bus.dec) begin
            if (count_q == MAX_V) begin
                ovf_d      = 1'b1;
                next_count = (SAT_MODE == MODE_SAT) ? MAX_V : '0;
            end else begin
                next_count = count_q + 1'b1;
            end
        end else if (bus.dec && !bus.inc) begin
            if (count_q == '0) begin
                unf_d      = 1'b1;
                next_count = (SAT_MODE == MODE_SAT) ? '0 : MAX_V;
            end else begin
                next_count = count_q - 1'b1;
            end
        end
    end

    limit_compare #(
        .WIDTH (WIDTH),
        .LIMIT (LIMIT),
        .HYST  (HYST)
    ) u_limit_compare (
        .next_count (next_count),
        .gt_limit   (gt_limit),
        .le_release (le_release)
    );

    always_comb begin
        state_d = state_q;
        entry   = 1'b0;
        case (state_q)
            ST_BELOW: begin
                if (gt_limit) begin
                    state_d = ST_ABOVE;
                    entry   = 1'b1;
                end
            end
            ST_ABOVE: begin
                if (le_release) state_d = ST_BELOW;
            end
            default: state_d = ST_BELOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            state_q <= ST_BELOW;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= next_count;
            state_q <= state_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

`ifdef LIMIT_ALARM_LATCH_EN
    logic alarm_q;

    // A fresh entry outranks an ack arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alarm_q <= 1'b0;
        end else if (entry) begin
            alarm_q <= 1'b1;
        end else if (bus.alarm_ack) begin
            alarm_q <= 1'b0;
        end
    end

    assign bus.alarm = alarm_q;
`else
    logic unused_alarm_sig;
    assign unused_alarm_sig = ^{bus.alarm_ack, entry};
    assign bus.alarm        = (state_q == ST_ABOVE);
`endif

    assign bus.count       = count_q;
    assign bus.above_limit = (state_q == ST_ABOVE);
    assign bus.at_max      = (count_q == MAX_V);
    assign bus.at_min      = (count_q == '0);
    assign bus.ovf_pulse   = ovf_q;
    assign bus.unf_pulse   = unf_q;

endmodule
